wide_add_sequencer: RTL and testbench
=====================================

// Module: wide_add_sequencer
// PURPOSE
//  Multi-cycle controller that performs WORDS*32-bit add/subtract by time-multiplexing the 32-bit
//  carry-select adder, one word per cycle, LSW first, with the carry chained through a register.
//  Sits directly upstream of the 32-bit adder (drives its a/b/cin) and consumes its sum/cout.
//  Client side uses valid/ready handshakes on the command and the result.
// PARAMETERS
//  WORDS  4  number of 32-bit words per operand (legal 2..8); operand width W = 32*WORDS
// PORTS
//  clk          in   1   clock; all state changes on rising edge
//  rst          in   1   reset, synchronous, active-high
//  in_valid     in   1   command valid
//  in_ready     out  1   command accepted when in_valid & in_ready at a rising edge
//  op_sub       in   1   0 = A+B+op_cin, 1 = A-B (A + ~B + 1; op_cin ignored)
//  op_cin       in   1   carry-in for add
//  op_a         in   W   operand A (unsigned / two's complement)
//  op_b         in   W   operand B
//  adder_a      out  32  word of A to the 32-bit adder
//  adder_b      out  32  word of B (inverted when sub) to the 32-bit adder
//  adder_cin    out  1   chained carry to the 32-bit adder
//  adder_sum    in   32  adder sum (combinational return)
//  adder_cout   in   1   adder carry-out (combinational return)
//  out_valid    out  1   result valid
//  out_ready    in   1   result consumed when out_valid & out_ready at a rising edge
//  res_sum      out  W   result
//  res_cout     out  1   carry-out of MSW (for sub: 1 = no borrow)
//  res_overflow out  1   signed overflow of the full W-bit operation
//  res_zero     out  1   res_sum == 0
// BEHAVIOUR
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. On accept: latch op_a, op_b ^ {W{op_sub}}, op_sub; carry <= op_sub ? 1 : op_cin;
//        idx <= 0; zero_acc <= 1; -> RUN.
//  RUN:  adder_a = A[idx], adder_b = B'[idx], adder_cin = carry (combinational from registers).
//        Each edge: res_sum[idx] <= adder_sum; carry <= adder_cout; zero_acc &= (adder_sum==0);
//        idx <= idx+1. On idx==WORDS-1: res_cout <= adder_cout;
//        res_overflow <= (A[W-1]==B'[W-1]) & (adder_sum[31]!=A[W-1]); res_zero <= zero_acc & (adder_sum==0); -> DONE.
//  DONE: out_valid=1; res_* held stable; in_ready=0. On out_ready edge -> IDLE (out_valid drops next cycle).
//  Latency: accept at edge 0 -> out_valid high after edge WORDS; min issue interval WORDS+2 cycles.
//  in_ready=0 in RUN and DONE; commands offered then are not accepted, op_* ignored.
//  Outside RUN: adder_a=0, adder_b=0, adder_cin=0.
//  Overflow computed internally from top-word signs; adder's own overflow output is not used.
//  res_* keep last result through IDLE until overwritten by the next RUN.
//  Reset (any state, incl. mid-RUN): next cycle state=IDLE, in_ready=1, out_valid=0, idx=0, carry=0,
//   res_sum=0, res_cout=0, res_overflow=0, res_zero=0, adder_* = 0; in-flight op discarded, no result.
//  in_valid asserted in the reset cycle is not accepted.
// TESTING (WORDS=4, W=128; behavioural 32-bit adder model attached)
//  1 add A=2^128-1, B=1, cin=0 -> res_sum=0, res_cout=1, res_zero=1, res_overflow=0; out_valid 4 edges after accept.
//  2 sub A=0, B=1 -> res_sum=all-ones, res_cout=0, res_overflow=0, res_zero=0.
//  3 add A=0x7FFF..FF, B=1 -> res_sum=0x8000..00, res_overflow=1, res_cout=0; also A=0x8000..00 minus 1 -> overflow=1.
//  4 carry across words: A=0x0..0_FFFFFFFF_FFFFFFFF, B=0, cin=1 -> res_sum=0x0..1_00000000_00000000.
//  5 out_ready low 10 cycles with in_valid high -> res_* stable, in_ready=0, no second accept; release -> IDLE, accept next edge.
//  6 rst pulse at idx=2 of RUN -> next cycle out_valid=0, in_ready=1, adder_*=0; new command completes correctly.

Source files
------------

// File: rtl/wide_add_sequencer_if.sv
// wide_add_sequencer_if: command, result and 32-bit adder signals of the wide add sequencer
interface wide_add_sequencer_if #(parameter int WORDS = 4) ();
  localparam int W = 32 * WORDS;
  logic in_valid;
  logic in_ready;
  logic op_sub;
  logic op_cin;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [31:0] adder_a;
  logic [31:0] adder_b;
  logic adder_cin;
  logic [31:0] adder_sum;
  logic adder_cout;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] res_sum;
  logic res_cout;
  logic res_overflow;
  logic res_zero;
  modport slave (
    input in_valid, op_sub, op_cin, op_a, op_b, adder_sum, adder_cout, out_ready,
    output in_ready, adder_a, adder_b, adder_cin, out_valid, res_sum, res_cout, res_overflow, res_zero
  );
  modport master (
    output in_valid, op_sub, op_cin, op_a, op_b, adder_sum, adder_cout, out_ready,
    input in_ready, adder_a, adder_b, adder_cin, out_valid, res_sum, res_cout, res_overflow, res_zero
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: WORDS*32-bit add/sub by feeding one word per cycle through a shared 32-bit adder
module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input logic clk,
  input logic rst,
  wide_add_sequencer_if.slave bus
);
  localparam int W = 32 * WORDS;
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [IW-1:0] idx;
  logic carry;
  logic zero_acc;
  logic last;
  logic sum_zero;
  logic run;
  assign run = state == RUN;
  assign last = idx == IW'(WORDS - 1);
  assign sum_zero = bus.adder_sum == '0;
  assign bus.adder_a = run ? a_r[32*idx +: 32] : '0;
  assign bus.adder_b = run ? b_r[32*idx +: 32] : '0;
  assign bus.adder_cin = run ? carry : 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      idx <= '0;
      carry <= 1'b0;
      zero_acc <= 1'b0;
      bus.res_sum <= '0;
      bus.res_cout <= 1'b0;
      bus.res_overflow <= 1'b0;
      bus.res_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r <= bus.op_a;
          b_r <= bus.op_b ^ {W{bus.op_sub}};
          carry <= bus.op_sub | bus.op_cin;
          idx <= '0;
          zero_acc <= 1'b1;
          bus.in_ready <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          bus.res_sum[32*idx +: 32] <= bus.adder_sum;
          carry <= bus.adder_cout;
          zero_acc <= zero_acc & sum_zero;
          idx <= idx + 1'b1;
          if (last) begin
            // Signed overflow from the top-word signs of A and the (possibly inverted) B
            bus.res_cout <= bus.adder_cout;
            bus.res_overflow <= (a_r[W-1] == b_r[W-1]) & (bus.adder_sum[31] != a_r[W-1]);
            bus.res_zero <= zero_acc & sum_zero;
            bus.out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed tests of the wide add sequencer with a behavioural 32-bit adder
module tb_wide_add_sequencer;
  localparam int WORDS = 4;
  localparam int W = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  wide_add_sequencer_if #(.WORDS(WORDS)) bus ();
  wide_add_sequencer #(.WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign {bus.adder_cout, bus.adder_sum} = {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {32'd0, bus.adder_cin};
  always #5 clk = ~clk;

  task automatic issue(input logic sub, input logic cin, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got %b exp 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.op_sub = sub;
    bus.op_cin = cin;
    bus.op_a = a;
    bus.op_b = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.op_sub = 1'b0;
    bus.op_cin = 1'b0;
    bus.op_a = '1;
    bus.op_b = '1;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake got ready=%b valid=%b exp 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.res_sum !== '0 || {bus.res_cout, bus.res_overflow, bus.res_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_result got %h %b%b%b exp 0 000", bus.res_sum, bus.res_cout, bus.res_overflow, bus.res_zero);
    end
    checks++;
    if ({bus.adder_a, bus.adder_b, bus.adder_cin} !== 65'd0) begin
      errors++;
      $display("FAIL reset_adder got %h %h %b exp 0", bus.adder_a, bus.adder_b, bus.adder_cin);
    end
  endtask

  task automatic test_add_wrap();
    int lat;
    issue(1'b0, 1'b0, {W{1'b1}}, 128'd1);
    wait_done(lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL wrap_latency got %0d exp 4", lat);
    end
    checks++;
    if (bus.res_sum !== 128'd0 || {bus.res_cout, bus.res_overflow, bus.res_zero} !== 3'b101) begin
      errors++;
      $display("FAIL wrap_result got %h cout/ovf/zero %b%b%b exp 0 101", bus.res_sum, bus.res_cout, bus.res_overflow, bus.res_zero);
    end
    consume();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.res_zero !== 1'b1) begin
      errors++;
      $display("FAIL wrap_idle got valid=%b ready=%b zero=%b exp 0 1 1", bus.out_valid, bus.in_ready, bus.res_zero);
    end
  endtask

  task automatic test_sub();
    int lat;
    issue(1'b1, 1'b0, 128'd0, 128'd1);
    checks++;
    if (bus.adder_a !== 32'd0 || bus.adder_b !== 32'hFFFF_FFFE || bus.adder_cin !== 1'b1) begin
      errors++;
      $display("FAIL sub_word0 got %h %h %b exp 0 fffffffe 1", bus.adder_a, bus.adder_b, bus.adder_cin);
    end
    wait_done(lat);
    checks++;
    if (bus.res_sum !== {W{1'b1}} || {bus.res_cout, bus.res_overflow, bus.res_zero} !== 3'b000) begin
      errors++;
      $display("FAIL sub_result got %h %b%b%b exp all-ones 000", bus.res_sum, bus.res_cout, bus.res_overflow, bus.res_zero);
    end
    consume();
  endtask

  task automatic test_overflow();
    int lat;
    issue(1'b0, 1'b0, {1'b0, {(W-1){1'b1}}}, 128'd1);
    wait_done(lat);
    checks++;
    if (bus.res_sum !== {1'b1, {(W-1){1'b0}}} || {bus.res_cout, bus.res_overflow, bus.res_zero} !== 3'b010) begin
      errors++;
      $display("FAIL ovf_add got %h %b%b%b exp 8000..0 010", bus.res_sum, bus.res_cout, bus.res_overflow, bus.res_zero);
    end
    consume();
    issue(1'b1, 1'b0, {1'b1, {(W-1){1'b0}}}, 128'd1);
    wait_done(lat);
    checks++;
    if (bus.res_sum !== {1'b0, {(W-1){1'b1}}} || {bus.res_cout, bus.res_overflow, bus.res_zero} !== 3'b110) begin
      errors++;
      $display("FAIL ovf_sub got %h %b%b%b exp 7fff..f 110", bus.res_sum, bus.res_cout, bus.res_overflow, bus.res_zero);
    end
    consume();
  endtask

  task automatic test_carry_chain();
    int lat;
    issue(1'b0, 1'b1, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd0);
    wait_done(lat);
    checks++;
    if (bus.res_sum !== 128'h0000_0000_0000_0001_0000_0000_0000_0000 || {bus.res_cout, bus.res_overflow, bus.res_zero} !== 3'b000) begin
      errors++;
      $display("FAIL carry_chain got %h %b%b%b exp 1_00000000_00000000 000", bus.res_sum, bus.res_cout, bus.res_overflow, bus.res_zero);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] held;
    logic ready_seen = 1'b0;
    logic valid_drop = 1'b0;
    logic sum_moved = 1'b0;
    issue(1'b0, 1'b0, 128'd100, 128'd23);
    wait_done(lat);
    held = bus.res_sum;
    checks++;
    if (held !== 128'd123) begin
      errors++;
      $display("FAIL bp_first got %h exp 7b", held);
    end
    bus.in_valid = 1'b1;
    bus.op_sub = 1'b0;
    bus.op_cin = 1'b0;
    bus.op_a = 128'd5;
    bus.op_b = 128'd7;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      ready_seen |= bus.in_ready;
      valid_drop |= ~bus.out_valid;
      sum_moved |= bus.res_sum !== held;
    end
    checks++;
    if ({ready_seen, valid_drop, sum_moved} !== 3'b000) begin
      errors++;
      $display("FAIL bp_hold got ready/drop/moved %b%b%b exp 000", ready_seen, valid_drop, sum_moved);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got ready=%b valid=%b exp 1 0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got ready=%b exp 0", bus.in_ready);
    end
    wait_done(lat);
    checks++;
    if (lat !== 4 || bus.res_sum !== 128'd12) begin
      errors++;
      $display("FAIL bp_second got lat=%0d sum=%h exp 4 c", lat, bus.res_sum);
    end
    consume();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    issue(1'b0, 1'b0, 128'd1, 128'd2);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_run_handshake got valid=%b ready=%b exp 0 1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if ({bus.adder_a, bus.adder_b, bus.adder_cin} !== 65'd0 || bus.res_sum !== '0) begin
      errors++;
      $display("FAIL rst_run_clear got %h %h %b sum %h exp 0", bus.adder_a, bus.adder_b, bus.adder_cin, bus.res_sum);
    end
    issue(1'b0, 1'b0, 128'h0000_0003_0000_0002_0000_0001_FFFF_FFFF, 128'd1);
    wait_done(lat);
    checks++;
    if (lat !== 4 || bus.res_sum !== 128'h0000_0003_0000_0002_0000_0002_0000_0000 || bus.res_cout !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_next got lat=%0d sum=%h cout=%b exp 4 3_2_2_0 0", lat, bus.res_sum, bus.res_cout);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_overflow();
    test_carry_chain();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
